// File: rtl/rf_operand_fetch.sv
// Operand fetch / writeback controller for a 32-entry register file with a busy scoreboard.
// Define RF_FWD_EN to forward same-cycle writeback data into the operand path.
//   state | meaning
//   EMPTY | output register holds no entry (out_valid=0)
//   FULL  | output register holds an entry for execute (out_valid=1)
module rf_operand_fetch #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic             in_wr_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_opA,
  output logic [WIDTH-1:0] out_opB,
  output logic [4:0]       out_rd,
  output logic             out_wr_en,
  input  logic             wb_valid,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             rf_write,
  output logic [4:0]       rf_wrAddr,
  output logic [WIDTH-1:0] rf_wrData,
  output logic [4:0]       rf_rdAddrA,
  output logic [4:0]       rf_rdAddrB,
  input  logic [WIDTH-1:0] rf_rdDataA,
  input  logic [WIDTH-1:0] rf_rdDataB,
  output logic [31:0]      sb_busy
);

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [4:0]       rd_q, rd_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      sb_busy_q, sb_busy_d;

  logic             fwd_a, fwd_b;
  logic             hz_a, hz_b, hz_d, hazard, issue;
  logic [WIDTH-1:0] sel_a, sel_b;

`ifdef RF_FWD_EN
  assign fwd_a = wb_valid && (wb_addr == in_rs1) && (in_rs1 != ZR);
  assign fwd_b = wb_valid && (wb_addr == in_rs2) && (in_rs2 != ZR);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  always_comb begin
    hz_a     = (in_rs1 != ZR) && sb_busy_q[in_rs1] && !fwd_a;
    hz_b     = (in_rs2 != ZR) && sb_busy_q[in_rs2] && !fwd_b;
    hz_d     = in_wr_en && (in_rd != ZR) && sb_busy_q[in_rd];
    hazard   = hz_a || hz_b || hz_d;
    // Independent of in_valid so upstream can rely on it without a loop.
    in_ready = (!out_valid || out_ready) && !hazard;
    issue    = in_valid && in_ready;
  end

  always_comb begin
    sel_a = rf_rdDataA;
    if (in_rs1 == ZR)  sel_a = '0;
    else if (fwd_a)    sel_a = wb_data;
    sel_b = rf_rdDataB;
    if (in_rs2 == ZR)  sel_b = '0;
    else if (fwd_b)    sel_b = wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (issue) state_d = FULL;
      FULL:    if (out_ready && !issue) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
  end

  always_comb begin
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    rd_d    = rd_q;
    wr_en_d = wr_en_q;
    if (issue) begin
      op_a_d  = sel_a;
      op_b_d  = sel_b;
      rd_d    = in_rd;
      wr_en_d = in_wr_en;
    end
  end

  // Clear before set: a same-cycle set only happens on a non-busy register.
  always_comb begin
    sb_busy_d = sb_busy_q;
    if (wb_valid) sb_busy_d[wb_addr] = 1'b0;
    if (issue && in_wr_en && (in_rd != ZR)) sb_busy_d[in_rd] = 1'b1;
    sb_busy_d[ZR] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      rd_q      <= '0;
      wr_en_q   <= 1'b0;
      sb_busy_q <= '0;
    end else begin
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      rd_q      <= rd_d;
      wr_en_q   <= wr_en_d;
      sb_busy_q <= sb_busy_d;
    end
  end

  always_comb begin
    out_opA    = op_a_q;
    out_opB    = op_b_q;
    out_rd     = rd_q;
    out_wr_en  = wr_en_q;
    sb_busy    = sb_busy_q;
    rf_rdAddrA = in_rs1;
    rf_rdAddrB = in_rs2;
    rf_write   = wb_valid && (wb_addr != ZR);
    rf_wrAddr  = wb_addr;
    rf_wrData  = wb_data;
  end

endmodule

// File: doc/rf_operand_fetch.md
# rf_operand_fetch

- Operand-fetch and writeback controller that drives the 32x64 register file from the initiator side.
- Accepts decoded instructions (rs1, rs2, rd) through a valid/ready handshake, sequences both read ports, and presents registered operands to the execute stage through a one-entry output register.
- Owns the register-file write port for writeback and tracks pending destination registers in a 32-bit scoreboard, stalling read-after-write and write-after-write hazards.
- Register ZERO_REG is hardwired zero: it reads as 0 and ignores writes.

## Interface
Parameters:
- WIDTH, 64, data width of operands and writeback
- ZERO_REG, 31, index of the hardwired-zero register

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_rs1, in_rs2, in_rd  in  5 each  source and destination register indices
- in_wr_en  in  1  instruction will write rd
- out_valid  out  1  operand register holds a valid entry
- out_ready  in  1  execute stage consumes the entry
- out_opA, out_opB  out  WIDTH each  fetched operands
- out_rd  out  5  destination index, passed through
- out_wr_en  out  1  destination write flag, passed through
- wb_valid  in  1  writeback request this cycle
- wb_addr  in  5  writeback register index
- wb_data  in  WIDTH  writeback data
- rf_write  out  1  register-file write enable
- rf_wrAddr  out  5  register-file write address
- rf_wrData  out  WIDTH  register-file write data
- rf_rdAddrA, rf_rdAddrB  out  5 each  register-file read addresses
- rf_rdDataA, rf_rdDataB  in  WIDTH each  register-file combinational read data
- sb_busy  out  32  scoreboard bits, one per register

## Operation
- Output register is a two-state FSM:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY->FULL on issue.
  - FULL->EMPTY on out_ready with no issue.
  - FULL->FULL on out_ready with issue (back-to-back transfer).
- Read addresses: rf_rdAddrA=in_rs1 and rf_rdAddrB=in_rs2 at all times (combinational).
- Hazard: hazard = src_hz(rs1) || src_hz(rs2) || (in_wr_en && rd!=ZERO_REG && sb_busy[rd]).
  - src_hz(r) = r!=ZERO_REG && sb_busy[r] && !fwd(r).
- in_ready = (!out_valid || out_ready) && !hazard. It is combinational and does not depend on in_valid.
- Issue = in_valid && in_ready. On issue:
  - opA = 0 if rs1==ZERO_REG; else wb_data if fwd(rs1); else rf_rdDataA. opB is derived the same way from rs2.
  - rd and wr_en are latched into out_rd and out_wr_en.
  - sb_busy[rd] is set if in_wr_en && rd!=ZERO_REG.
- Writeback when wb_valid:
  - rf_write = wb_valid && wb_addr!=ZERO_REG.
  - rf_wrAddr=wb_addr, rf_wrData=wb_data.
  - sb_busy[wb_addr] clears at the edge.
  - A writeback to a non-busy register is legal and simply writes.
- Same bit set and cleared in one cycle: set wins. This only occurs when the register was not busy.
- sb_busy[ZERO_REG] is always 0.
- With out_valid=1 and out_ready=0, the held outputs are stable.

## Timing
- Reset (async assert, sync-safe deassert): out_valid=0, out_opA=0, out_opB=0, out_rd=0, out_wr_en=0, sb_busy=0.
- Combinational outputs during reset:
  - in_ready = 1.
  - rf_write follows wb_valid, so a writeback presented during reset still writes the register file.
- Latency: an instruction accepted at edge N is on the out_* ports after edge N. Throughput is one per cycle.
- Register-file write lands at the edge after wb_valid. Reading the same register in that cycle returns the old value from the register file, so forwarding or a stall covers this case.
- Reset asserted mid-operation: the held entry and all scoreboard bits are lost.

## Configuration
- RF_FWD_EN defined:
  - fwd(r) = wb_valid && wb_addr==r && r!=ZERO_REG.
  - An instruction whose source is being written back in the same cycle issues that cycle with wb_data.
- RF_FWD_EN undefined:
  - fwd(r)=0. The source stays busy until the writeback edge.
  - The instruction issues one cycle later and reads the newly written value from the register file.

## Test plan
- Reset then idle: out_valid=0, sb_busy=0, in_ready=1.
- Write via wb (x5=0x1234), then issue rs1=5, rs2=31, rd=6, wr_en=1:
  - next cycle out_opA=0x1234, out_opB=0, sb_busy[6]=1.
- RAW: issue rd=7, then rs1=7:
  - in_ready=0 until wb_valid with wb_addr=7, wb_data=0xABCD.
  - With RF_FWD_EN it issues in the wb cycle with out_opA=0xABCD.
  - Without RF_FWD_EN it issues one cycle later with the same value.
- Backpressure: out_ready=0 with FULL:
  - in_ready=0 and outputs hold.
  - Assert out_ready together with a new in_valid: back-to-back transfer, and out_valid stays 1.
- WAW and zero register:
  - Issue rd=9 twice: the second stalls until the wb to 9.
  - wb_addr=31 gives rf_write=0.
  - rd=31 never sets sb_busy.
- Assert rst_n=0 while FULL with busy bits set: out_valid=0 and sb_busy=0 immediately, without waiting for a clock.
